dac_frame_sequencer: RTL and testbench
======================================

// Module: dac_frame_sequencer
// PURPOSE
//  Upstream feeder for the DAC SPI byte controller. Accepts 16-bit DAC samples with a 2-bit channel
//  over a valid/ready handshake, builds a 3-byte DAC write frame and issues it byte-by-byte as
//  o_Data plus a 1-cycle o_Send pulse. The controller has no busy/done output, so bytes are paced
//  by a fixed inter-byte gap timer. After reset, one wake byte is issued to run the controller's SPI init.
// PARAMETERS
//  BYTE_GAP     64    clocks from one o_Send pulse to the next; must be >= 16 (covers SPI byte time + ctrl SM)
//  CMD_NIBBLE   4'h3  upper nibble of command byte (write-and-update)
//  FIFO_DEPTH   4     sample FIFO depth, power of 2; used only when DAC_SEQ_FIFO_EN is defined
// PORTS
//  i_Clock          in   1   system clock; the only clock
//  i_Reset          in   1   synchronous, active-high reset
//  i_Sample_Valid   in   1   sample presented
//  i_Sample         in   16  DAC code, unsigned
//  i_Channel        in   2   DAC channel A..D
//  o_Sample_Ready   out  1   sample accepted on cycle where valid & ready
//  o_Data           out  8   byte to SPI controller
//  o_Send           out  1   1-cycle strobe: o_Data is valid
//  o_Busy           out  1   high while frame/wake in progress or samples pending
// BEHAVIOUR
//  Reset values: o_Data=8'h00, o_Send=0, o_Sample_Ready=0, o_Busy=1, state=S_WAKE, gap counter=0.
//  Frame: byte0={CMD_NIBBLE,2'b00,channel}, byte1=sample[15:8], byte2=sample[7:0], sent in that order.
//  States:
//   S_WAKE: o_Data=8'h00, o_Send=1 for one cycle -> S_WAKE_GAP.
//   S_WAKE_GAP: count BYTE_GAP-1 cycles -> S_IDLE.
//   S_IDLE: o_Sample_Ready=1 (no FIFO). On valid&ready latch sample+channel -> S_BYTE (index 0).
//   S_BYTE: drive o_Data=frame[index], o_Send=1 for exactly one cycle -> S_GAP.
//   S_GAP: count BYTE_GAP-1 cycles; then index<2 -> S_BYTE (index+1), else -> S_IDLE.
//  Timing: sample accepted cycle N -> byte0 o_Send at N+1; byte1 at N+1+BYTE_GAP; byte2 at N+1+2*BYTE_GAP;
//   next sample accepted no earlier than N+1+3*BYTE_GAP. o_Send pulses always exactly BYTE_GAP apart in a frame.
//  o_Data holds its value from its o_Send cycle until the next o_Send; never changes while o_Send=1.
//  o_Sample_Ready is combinationally low in every state other than S_IDLE (no FIFO); sample/channel
//   inputs are ignored when not ready. Gap counter: $clog2(BYTE_GAP) bits, counts up, clears on exit.
//  o_Busy = (state != S_IDLE) | samples pending.
//  Reset mid-frame: frame dropped, no further o_Send of that frame; S_WAKE re-issued after reset deasserts.
//  Reset asserted the same cycle as valid: sample not accepted.
// CONFIGURATION
//  DAC_SEQ_FIFO_EN defined: samples go through a FIFO_DEPTH-entry {channel,sample} FIFO;
//   o_Sample_Ready = !full in all states (incl. during wake); S_IDLE pops when !empty; back-to-back
//   frames: byte0 of next frame BYTE_GAP after byte2 of previous (S_GAP exits straight to S_BYTE on pop).
//   Push and pop in the same cycle when full: pop first, push accepted. Reset empties FIFO.
//  Undefined: single holding register, behaviour as above; FIFO_DEPTH ignored.
// STRUCTURE
//  Package dac_seq_pkg: state enum (S_WAKE,S_WAKE_GAP,S_IDLE,S_BYTE,S_GAP), WAKE_BYTE=8'h00,
//   frame byte index constants, sample/channel widths.
//  Sub-module dac_seq_fifo (synchronous FIFO, occupancy count, full/empty) instantiated only under
//   DAC_SEQ_FIFO_EN; sequencer FSM + gap counter in this module.
// TESTING
//  Release reset, BYTE_GAP=16 -> one o_Send with o_Data=00 at first post-reset cycle; ready rises 16 cycles later.
//  Sample 16'hABCD ch 2 -> o_Send bytes 32,AB,CD spaced exactly 16 cycles; ready low throughout; o_Busy falls after.
//  Valid held high with new sample during frame -> not accepted until S_IDLE; accepted value = value held then.
//  Reset 3 cycles after byte1 strobe -> no byte2; wake byte 00 re-sent; next sample frames correctly.
//  FIFO_EN, push 5 samples back-to-back, depth 4 -> 4 accepted, ready low on 5th until first pop; 12 bytes, 16-cycle spacing.
//  Channel 3, sample 16'h0000 and 16'hFFFF -> bytes 33,00,00 and 33,FF,FF.

Source files
------------

// File: rtl/dac_seq_pkg.sv
// Shared types and constants for the DAC frame sequencer: FSM state codes,
// frame byte indices, the {channel,sample} record and the frame byte builder.
package dac_seq_pkg;

  localparam int SAMPLE_W = 16;
  localparam int CHAN_W   = 2;

  localparam logic [7:0] WAKE_BYTE = 8'h00;

  localparam logic [1:0] IDX_CMD = 2'd0;
  localparam logic [1:0] IDX_MSB = 2'd1;
  localparam logic [1:0] IDX_LSB = 2'd2;

  typedef logic [2:0] state_t;
  localparam state_t S_WAKE     = 3'd0;
  localparam state_t S_WAKE_GAP = 3'd1;
  localparam state_t S_IDLE     = 3'd2;
  localparam state_t S_BYTE     = 3'd3;
  localparam state_t S_GAP      = 3'd4;

  typedef struct packed {
    logic [CHAN_W-1:0]   ch;
    logic [SAMPLE_W-1:0] smp;
  } sample_t;

  function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                            input logic [3:0] cmd,
                                            input sample_t    s);
    case (idx)
      IDX_CMD: frame_byte = {cmd, 2'b00, s.ch};
      IDX_MSB: frame_byte = s.smp[15:8];
      default: frame_byte = s.smp[7:0];
    endcase
  endfunction

endpackage

// File: rtl/dac_seq_fifo.sv
// Small synchronous FIFO of {channel,sample} records with occupancy count.
// Used by dac_frame_sequencer only when DAC_SEQ_FIFO_EN is defined.
module dac_seq_fifo
  import dac_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  sample_t                data_i,
  input  logic                   pop_i,
  output sample_t                data_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  sample_t              mem_q [DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [AW:0]          cnt_q, cnt_d;
  logic                 do_push, do_pop;

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && (!full_o || do_pop);

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/dac_frame_sequencer.sv
// Turns {channel,sample} writes into paced 3-byte DAC frames for the SPI byte controller.
// Optional feature macro: DAC_SEQ_FIFO_EN (sample FIFO instead of a single holding register).
module dac_frame_sequencer
  import dac_seq_pkg::*;
#(
  parameter int         BYTE_GAP   = 64,
  parameter logic [3:0] CMD_NIBBLE = 4'h3,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                i_Clock,
  input  logic                i_Reset,
  input  logic                i_Sample_Valid,
  input  logic [SAMPLE_W-1:0] i_Sample,
  input  logic [CHAN_W-1:0]   i_Channel,
  output logic                o_Sample_Ready,
  output logic [7:0]          o_Data,
  output logic                o_Send,
  output logic                o_Busy
);

  localparam int             CNT_W    = $clog2(BYTE_GAP);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(BYTE_GAP - 2);

  if (BYTE_GAP < 16 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("dac_frame_sequencer: BYTE_GAP must be >= 16 and FIFO_DEPTH a power of 2");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [7:0]         data_q, data_d;
  sample_t            frame_q, frame_d;
  sample_t            in_smp;
  logic               take, pending, gap_done;

  assign gap_done = (cnt_q == GAP_LAST);

`ifdef DAC_SEQ_FIFO_EN
  sample_t                     fifo_dout;
  logic                        fifo_full;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  // Pop in idle, or straight from the last gap of a frame for back-to-back frames.
  assign pending        = (fifo_count != '0);
  assign take           = pending && ((state_q == S_IDLE) ||
                          (state_q == S_GAP && gap_done && idx_q == IDX_LSB));
  assign o_Sample_Ready = (!fifo_full || take) && !i_Reset;
  assign in_smp         = fifo_dout;

  dac_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (i_Clock),
    .rst_i   (i_Reset),
    .push_i  (i_Sample_Valid && o_Sample_Ready),
    .data_i  ({i_Channel, i_Sample}),
    .pop_i   (take),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );
`else
  assign pending        = 1'b0;
  assign o_Sample_Ready = (state_q == S_IDLE) && !i_Reset;
  assign take           = i_Sample_Valid && o_Sample_Ready;
  assign in_smp         = {i_Channel, i_Sample};
`endif

  // o_Data is loaded on the edge into S_BYTE so it is stable for the whole strobe cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    frame_d = frame_q;
    case (state_q)
      S_WAKE: state_d = S_WAKE_GAP;
      S_WAKE_GAP: begin
        if (gap_done) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (take) begin
          frame_d = in_smp;
          idx_d   = IDX_CMD;
          data_d  = frame_byte(IDX_CMD, CMD_NIBBLE, in_smp);
          state_d = S_BYTE;
        end
      end
      S_BYTE: state_d = S_GAP;
      S_GAP: begin
        if (!gap_done) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (idx_q != IDX_LSB) begin
            idx_d   = idx_q + 2'd1;
            data_d  = frame_byte(idx_q + 2'd1, CMD_NIBBLE, frame_q);
            state_d = S_BYTE;
          end else if (take) begin
            frame_d = in_smp;
            idx_d   = IDX_CMD;
            data_d  = frame_byte(IDX_CMD, CMD_NIBBLE, in_smp);
            state_d = S_BYTE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_WAKE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= S_WAKE;
      cnt_q   <= '0;
      idx_q   <= IDX_CMD;
      data_q  <= WAKE_BYTE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    frame_q <= frame_d;
  end

  assign o_Data = data_q;
  assign o_Send = ((state_q == S_WAKE) || (state_q == S_BYTE)) && !i_Reset;
  assign o_Busy = (state_q != S_IDLE) || pending || i_Reset;

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Self-checking bench for dac_frame_sequencer: directed steps plus random traffic,
// every cycle compared against a timing/queue model of the frame sequencer.
module tb_dac_frame_sequencer;

  localparam int G     = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, vld;
  logic [15:0] smp;
  logic [1:0]  ch;
  logic        rdy, send, busy;
  logic [7:0]  data;

  always #5 clk = ~clk;

  dac_frame_sequencer #(
    .BYTE_GAP   (G),
    .CMD_NIBBLE (4'h3),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Sample_Valid (vld),
    .i_Sample       (smp),
    .i_Channel      (ch),
    .o_Sample_Ready (rdy),
    .o_Data         (data),
    .o_Send         (send),
    .o_Busy         (busy)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [7:0]  sched [int];
  int          idle_from = 0;
  int          free_at   = 0;
  logic [7:0]  last_data = 8'h00;
  logic        rst_prev  = 1'b0;
  logic [17:0] q [$];
  logic [7:0]  log_q [$];

  function automatic logic [7:0] fb(logic [1:0] c, logic [15:0] s, int i);
    if (i == 0)      return {4'h3, 2'b00, c};
    else if (i == 1) return s[15:8];
    else             return s[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Frame started (accepted or popped) in cycle p: bytes at p+1, p+1+G, p+1+2G.
  task automatic frame_start(input int p, input logic [1:0] c, input logic [15:0] s);
    for (int i = 0; i < 3; i++) sched[p + 1 + i * G] = fb(c, s, i);
    idle_from = p + 1 + 3 * G;
    free_at   = p + 3 * G;
  endtask

  task automatic cycle(input logic r, input logic v, input logic [1:0] c,
                       input logic [15:0] s, output logic acc);
    logic        exp_rdy, exp_busy, exp_send, pop;
    logic [17:0] head;
    rst = r; vld = v; ch = c; smp = s;
    #1;
    acc = 1'b0;
    pop = 1'b0;
    if (r) begin
      chk("rst_ready", rdy, 0);
      chk("rst_send", send, 0);
      chk("rst_busy", busy, 1);
      if (rst_prev) chk("rst_data", data, 8'h00);
      sched.delete();
      q.delete();
      sched[cyc + 1] = 8'h00;
      idle_from = cyc + 1 + G;
      free_at   = idle_from;
      last_data = 8'h00;
    end else begin
`ifdef DAC_SEQ_FIFO_EN
      pop      = (q.size() > 0) && (cyc >= free_at);
      exp_rdy  = (q.size() < DEPTH) || pop;
      exp_busy = (cyc < idle_from) || (q.size() > 0);
`else
      exp_rdy  = (cyc >= idle_from);
      exp_busy = (cyc < idle_from);
`endif
      exp_send = sched.exists(cyc);
      chk("ready", rdy, exp_rdy);
      chk("busy", busy, exp_busy);
      chk("send", send, exp_send);
      if (exp_send) begin
        chk("data", data, sched[cyc]);
        last_data = sched[cyc];
        sched.delete(cyc);
      end else begin
        chk("data_hold", data, last_data);
      end
      if (send === 1'b1) log_q.push_back(data);
`ifdef DAC_SEQ_FIFO_EN
      if (pop) begin
        head = q.pop_front();
        frame_start(cyc, head[17:16], head[15:0]);
      end
      if (v && exp_rdy) begin
        q.push_back({c, s});
        acc = 1'b1;
      end
`else
      if (v && exp_rdy) begin
        frame_start(cyc, c, s);
        acc = 1'b1;
      end
`endif
    end
    rst_prev = r;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 16'h0000, a);
  endtask

  task automatic do_reset(input int n);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 2'd0, 16'h0000, a);
  endtask

  task automatic send_sample(input logic [1:0] c, input logic [15:0] s);
    logic a;
    a = 1'b0;
    for (int i = 0; i < 8 * G && !a; i++) cycle(1'b0, 1'b1, c, s, a);
    chk("accept_timeout", a, 1);
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 8 * G && log_q.size() < n; i++) run_idle(1);
    chk("byte_timeout", log_q.size() >= n, 1);
  endtask

  task automatic expect_frame(input int i0, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2);
    wait_log(i0 + 3);
    if (log_q.size() >= i0 + 3) begin
      chk("frame_b0", log_q[i0], b0);
      chk("frame_b1", log_q[i0 + 1], b1);
      chk("frame_b2", log_q[i0 + 2], b2);
    end
  endtask

  initial begin
    int   i0;
    logic a;
    rst = 1'b1; vld = 1'b0; ch = 2'd0; smp = 16'h0000;
    @(posedge clk);
    #1;

    // Reset, wake byte, ready rising after the wake gap.
    do_reset(3);
    run_idle(G + 4);
    chk("wake_logged", log_q.size(), 1);
    if (log_q.size() > 0) chk("wake_byte", log_q[0], 8'h00);

    // Directed frame, then a different sample held valid through it.
    i0 = log_q.size();
    send_sample(2'd2, 16'hABCD);
    send_sample(2'd1, 16'h1234);
    expect_frame(i0, 8'h32, 8'hAB, 8'hCD);
    expect_frame(i0 + 3, 8'h31, 8'h12, 8'h34);
    run_idle(3 * G + 4);

    // Extreme codes on channel 3.
    i0 = log_q.size();
    send_sample(2'd3, 16'h0000);
    send_sample(2'd3, 16'hFFFF);
    expect_frame(i0, 8'h33, 8'h00, 8'h00);
    expect_frame(i0 + 3, 8'h33, 8'hFF, 8'hFF);
    run_idle(3 * G + 4);

    // Reset three cycles after byte1: byte2 must never appear, wake is re-issued.
    i0 = log_q.size();
    send_sample(2'd0, 16'h5A5A);
    wait_log(i0 + 2);
    run_idle(3);
    do_reset(1);
    run_idle(2 * G);
    chk("reset_drop_len", log_q.size(), i0 + 3);
    if (log_q.size() >= i0 + 3) chk("reset_wake", log_q[i0 + 2], 8'h00);
    i0 = log_q.size();
    send_sample(2'd1, 16'h0F0F);
    expect_frame(i0, 8'h31, 8'h0F, 8'h0F);
    run_idle(3 * G + 4);

    // Reset coinciding with a valid sample: not accepted.
    i0 = log_q.size();
    cycle(1'b1, 1'b1, 2'd2, 16'hDEAD, a);
    run_idle(3 * G + 4);
    chk("rst_valid_only_wake", log_q.size(), i0 + 1);

`ifdef DAC_SEQ_FIFO_EN
    // Back-to-back pushes: FIFO fills, frames run with no idle gap.
    i0 = log_q.size();
    send_sample(2'd0, 16'h1111);
    send_sample(2'd1, 16'h2222);
    send_sample(2'd2, 16'h3333);
    send_sample(2'd3, 16'h4444);
    send_sample(2'd0, 16'h5555);
    expect_frame(i0, 8'h30, 8'h11, 8'h11);
    expect_frame(i0 + 12, 8'h30, 8'h55, 8'h55);
    run_idle(3 * G + 4);
`endif

    // Random traffic with changing data every cycle.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rv;
      rv = $urandom;
      cycle(1'b0, ($urandom_range(0, 3) == 0), rv[17:16], rv[15:0], a);
    end
    run_idle(8 * G);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
